// File: rtl/fpu_minmax_reduce_ctrl.sv
// FMIN/FMAX reduction sequencer: takes a job, folds LEN stream elements into an
// accumulator through one fpu_min_max comparator, then holds the result until consumed.

module fpu_min_max (
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        min_or_max_i,
    output logic [31:0] result_o,
    output logic        invalid_o
);
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_sig, b_sig;
    logic        a_nan, b_nan, b_snan, a_lt_b;

    always_comb begin
        a_sign = op_a_i[31];
        b_sign = op_b_i[31];
        a_exp  = op_a_i[30:23];
        b_exp  = op_b_i[30:23];
        a_sig  = {|a_exp, op_a_i[22:0]};
        b_sig  = {|b_exp, op_b_i[22:0]};
        a_nan  = (a_exp == 8'hFF) && (op_a_i[22:0] != 23'd0);
        b_nan  = (b_exp == 8'hFF) && (op_b_i[22:0] != 23'd0);
        b_snan = b_nan && !op_b_i[22];

        // Sign-magnitude ordering; differing signs make -0 below +0.
        if (a_sign != b_sign)
            a_lt_b = a_sign;
        else if (!a_sign)
            a_lt_b = {a_exp, a_sig} < {b_exp, b_sig};
        else
            a_lt_b = {a_exp, a_sig} > {b_exp, b_sig};

        if (a_nan && b_nan)
            result_o = 32'h7fc0_0000;
        else if (a_nan)
            result_o = op_b_i;
        else if (b_nan)
            result_o = op_a_i;
        else if (min_or_max_i)
            result_o = a_lt_b ? op_b_i : op_a_i;
        else
            result_o = a_lt_b ? op_a_i : op_b_i;

        // The accumulator is never signaling, so only B can raise invalid.
        invalid_o = b_snan;
    end
endmodule

module fpu_minmax_reduce_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    output logic             start_ready_o,
    input  logic [CNT_W-1:0] len_i,
    input  logic             min_or_max_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_invalid_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [31:0]      acc_q, acc_d;
    logic             inv_q, inv_d;
    logic             mode_q, mode_d;

    logic [31:0]      mm_result;
    logic             mm_invalid;

    fpu_min_max u_min_max (
        .op_a_i       (acc_q),
        .op_b_i       (in_data_i),
        .min_or_max_i (mode_q),
        .result_o     (mm_result),
        .invalid_o    (mm_invalid)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        inv_d   = inv_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d  = min_or_max_i;
                    rem_d   = len_i;
                    acc_d   = CANON_NAN;
                    inv_d   = 1'b0;
                    state_d = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (in_valid_i && rem_q != '0) begin
                    acc_d = mm_result;
                    inv_d = inv_q | mm_invalid;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1})
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= CANON_NAN;
            inv_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            inv_q   <= inv_d;
            mode_q  <= mode_d;
        end
    end

    // Handshake outputs decode only the state register, so no input reaches them combinationally.
    assign start_ready_o = (state_q == IDLE);
    assign in_ready_o    = (state_q == RUN);
    assign out_valid_o   = (state_q == DONE);
    assign out_data_o    = acc_q;
    assign out_invalid_o = inv_q;
endmodule

// File: tb/tb_fpu_minmax_reduce_ctrl.sv
// Directed-vector bench for fpu_minmax_reduce_ctrl with immediate-assertion checks.

module tb_fpu_minmax_reduce_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        start_ready_o;
    logic [7:0]  len_i;
    logic        min_or_max_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        out_invalid_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    fpu_minmax_reduce_ctrl #(.CNT_W(8)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .start_ready_o (start_ready_o),
        .len_i         (len_i),
        .min_or_max_i  (min_or_max_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_invalid_o (out_invalid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input logic [7:0] len, input logic mm);
        start_i = 1'b1; len_i = len; min_or_max_i = mm;
        tick();
        start_i = 1'b0;
        $display("start len=%0d max=%0b", len, mm);
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid_i = 1'b1; in_data_i = d;
        tick();
        in_valid_i = 1'b0;
        $display("elem %h", d);
    endtask

    task automatic finish_job(input string tag, input logic [31:0] exp_d, input logic exp_inv);
        chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        chk({tag, "_data"}, out_data_o, exp_d);
        chk({tag, "_inv"}, {31'd0, out_invalid_o}, {31'd0, exp_inv});
        $display("result %s data=%h inv=%0b", tag, out_data_o, out_invalid_o);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk({tag, "_idle"}, {30'd0, start_ready_o, out_valid_o}, 32'd2);
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; len_i = '0; min_or_max_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
        chk("rst_start_ready", {31'd0, start_ready_o}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_data", out_data_o, 32'h7fc00000);
        chk("rst_out_inv", {31'd0, out_invalid_o}, 32'd0);

        // max of 1.0, -2.0, 3.0
        start_job(8'd3, 1'b1);
        chk("t1_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("t1_start_ready", {31'd0, start_ready_o}, 32'd0);
        feed(32'h3F800000);
        chk("t1_first_pass", out_data_o, 32'h3F800000);
        feed(32'hC0000000);
        chk("t1_not_done", {31'd0, out_valid_o}, 32'd0);
        feed(32'h40400000);
        finish_job("t1", 32'h40400000, 1'b0);

        // signed zeros
        start_job(8'd2, 1'b0);
        feed(32'h00000000);
        feed(32'h80000000);
        finish_job("t2_min", 32'h80000000, 1'b0);
        start_job(8'd2, 1'b1);
        feed(32'h00000000);
        feed(32'h80000000);
        finish_job("t2_max", 32'h00000000, 1'b0);

        // qNaN, 1.0, sNaN
        start_job(8'd3, 1'b1);
        feed(32'h7FC00000);
        feed(32'h3F800000);
        feed(32'h7F800001);
        finish_job("t3", 32'h3F800000, 1'b1);

        // all NaN
        start_job(8'd2, 1'b0);
        feed(32'h7FC00001);
        feed(32'hFFC00000);
        finish_job("t4", 32'h7fc00000, 1'b0);

        // zero-length job
        start_job(8'd0, 1'b1);
        chk("t5_in_ready", {31'd0, in_ready_o}, 32'd0);
        finish_job("t5", 32'h7fc00000, 1'b0);

        // gaps on input, stalled output, start ignored
        start_job(8'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_gap_ready", {31'd0, in_ready_o}, 32'd1);
            chk("t6_gap_acc", out_data_o, 32'h7fc00000);
        end
        feed(32'h40000000);
        tick(); tick();
        chk("t6_hold_acc", out_data_o, 32'h40000000);
        chk("t6_hold_valid", {31'd0, out_valid_o}, 32'd0);
        feed(32'hBF800000);
        start_i = 1'b1; len_i = 8'd5; min_or_max_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_stall_valid", {31'd0, out_valid_o}, 32'd1);
            chk("t6_stall_data", out_data_o, 32'h40000000);
            chk("t6_stall_sready", {31'd0, start_ready_o}, 32'd0);
            tick();
        end
        start_i = 1'b0;
        finish_job("t6", 32'h40000000, 1'b0);

        // reset mid-RUN
        start_job(8'd3, 1'b0);
        feed(32'h7F800001);
        chk("t7_inv_set", {31'd0, out_invalid_o}, 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t7_rst_sready", {31'd0, start_ready_o}, 32'd1);
        chk("t7_rst_iready", {31'd0, in_ready_o}, 32'd0);
        chk("t7_rst_data", out_data_o, 32'h7fc00000);
        chk("t7_rst_inv", {31'd0, out_invalid_o}, 32'd0);
        start_job(8'd1, 1'b0);
        feed(32'hC0000000);
        finish_job("t7_next", 32'hC0000000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
